mod_interrupt: RTL and testbench

Memory-mapped interrupt controller, slot 10 on the CPU data bus, downstream of the bus arbiter's module decode. It latches rising edges from on-chip peripheral interrupt sources (UART, timer, GPIO, ...) into a pending register. It masks them and drives a single registered interrupt request to the CPU. It implements an acknowledge handshake that disables further requests until software re-enables them.

---
 rtl/mod_interrupt.sv | 164 ++++++++++++++++
 tb/tb_mod_interrupt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_interrupt.sv
// Interrupt controller for data-bus slot 10.
// Rising edges on peripheral interrupt lines are latched into a pending
// register. Pending sources are masked and combined into one registered
// request to the CPU. An acknowledge from the CPU drops the global enable
// until software turns it back on.
module mod_interrupt #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ie,
    input  logic            de,
    input  logic [31:0]     iaddr,
    input  logic [31:0]     daddr,
    input  logic            drw,
    input  logic [31:0]     din,
    output logic [31:0]     iout,
    output logic [31:0]     dout,
    input  logic [NSRC-1:0] irq_src,
    output logic            cpu_irq,
    input  logic            cpu_irq_ack
);

    // Register selects, taken from daddr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_INDEX  = 2'd3;

    // Zero padding that widens a source vector to the 32-bit bus
    localparam int PAD = 32 - NSRC;

    // Architectural state
    logic            gie_r;
    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] status_r;
    logic [NSRC-1:0] prev_r;
    logic            cpu_irq_r;

    // Decode and datapath
    logic [1:0]      sel_s;
    logic            wr_s;
    logic            rd_s;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] w1c_s;
    logic [NSRC-1:0] status_nxt_s;
    logic [NSRC-1:0] pend_s;
    logic            valid_s;
    logic [4:0]      idx_s;
    logic [31:0]     dout_s;

    // The instruction port, the address bits outside [3:2] and the write
    // data above the source range have no function in this block.
    logic            unused_s;

    // Index of the lowest set bit of v; 0 when v is empty.
    function automatic logic [4:0] lowest_set(input logic [NSRC-1:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

    assign sel_s    = daddr[3:2];
    assign wr_s     = de & drw;
    assign rd_s     = de & ~drw;
    assign unused_s = &{1'b0, ie, iaddr, daddr[31:4], daddr[1:0], din[31:NSRC]};

    // A line counts as an event only on the cycle it goes from low to high.
    assign rise_s = irq_src & ~prev_r;

    // Write-one-to-clear request for STATUS, empty unless STATUS is written
    always_comb begin
        w1c_s = {NSRC{1'b0}};
        if (wr_s && (sel_s == REG_STATUS)) begin
            w1c_s = din[NSRC-1:0];
        end else begin
            w1c_s = {NSRC{1'b0}};
        end
    end

    // Clear is applied before set so a capture in the same cycle survives.
    assign status_nxt_s = (status_r & ~w1c_s) | rise_s;

    // Enabled pending sources and their lowest-numbered member
    assign pend_s  = status_r & mask_r;
    assign valid_s = |pend_s;
    assign idx_s   = lowest_set(pend_s);

    // Edge-detect history and pending capture / clear
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r   <= {NSRC{1'b0}};
            status_r <= {NSRC{1'b0}};
        end else begin
            prev_r   <= irq_src;
            status_r <= status_nxt_s;
        end
    end

    // Source mask, written from the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= {NSRC{1'b0}};
        end else if (wr_s && (sel_s == REG_MASK)) begin
            mask_r <= din[NSRC-1:0];
        end else begin
            mask_r <= mask_r;
        end
    end

    // Global enable; an acknowledge overrides a simultaneous CTRL write
    always_ff @(posedge clk) begin
        if (rst) begin
            gie_r <= 1'b0;
        end else if (cpu_irq_ack) begin
            gie_r <= 1'b0;
        end else if (wr_s && (sel_s == REG_CTRL)) begin
            gie_r <= din[0];
        end else begin
            gie_r <= gie_r;
        end
    end

    // Registered request to the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_irq_r <= 1'b0;
        end else begin
            cpu_irq_r <= gie_r & valid_s;
        end
    end

    // Combinational read mux; idle bus reads as zero
    always_comb begin
        dout_s = 32'd0;
        if (rd_s) begin
            case (sel_s)
                REG_CTRL:   dout_s = {31'd0, gie_r};
                REG_MASK:   dout_s = {{PAD{1'b0}}, mask_r};
                REG_STATUS: dout_s = {{PAD{1'b0}}, status_r};
                REG_INDEX: begin
                    if (valid_s) begin
                        dout_s = {1'b1, 26'd0, idx_s};
                    end else begin
                        dout_s = 32'd0;
                    end
                end
                default:    dout_s = 32'd0;
            endcase
        end else begin
            dout_s = 32'd0;
        end
    end

    assign dout    = dout_s;
    assign iout    = 32'd0;
    assign cpu_irq = cpu_irq_r;

endmodule

// File: tb/tb_mod_interrupt.sv
// Bench for mod_interrupt: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle to a
// behavioural model of the controller.
module tb_mod_interrupt;

    localparam int NSRC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            ie;
    logic            de;
    logic [31:0]     iaddr;
    logic [31:0]     daddr;
    logic            drw;
    logic [31:0]     din;
    logic [31:0]     iout;
    logic [31:0]     dout;
    logic [NSRC-1:0] irq_src;
    logic            cpu_irq;
    logic            cpu_irq_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_interrupt #(.NSRC(NSRC)) dut (
        .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr),
        .daddr(daddr), .drw(drw), .din(din), .iout(iout), .dout(dout),
        .irq_src(irq_src), .cpu_irq(cpu_irq), .cpu_irq_ack(cpu_irq_ack)
    );

    // ---------------- behavioural model ----------------
    bit m_gie;
    bit m_mask [NSRC];
    bit m_pend [NSRC];
    bit m_prev [NSRC];
    bit m_irq;
    bit armed = 1'b0;

    function automatic bit model_request();
        for (int i = 0; i < NSRC; i++)
            if (m_mask[i] && m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input bit en, input bit w, input logic [1:0] sel);
        logic [31:0] r;
        r = 32'd0;
        if (!en || w) return 32'd0;
        case (sel)
            2'd0: r[0] = m_gie;
            2'd1: for (int i = 0; i < NSRC; i++) r[i] = m_mask[i];
            2'd2: for (int i = 0; i < NSRC; i++) r[i] = m_pend[i];
            default: begin
                for (int i = 0; i < NSRC; i++)
                    if (m_mask[i] && m_pend[i]) return 32'h8000_0000 + 32'(i);
            end
        endcase
        return r;
    endfunction

    // model state advance on each clock edge
    always @(posedge clk) begin
        armed <= armed | rst;
        if (rst) begin
            m_gie <= 1'b0;
            m_irq <= 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                m_mask[i] <= 1'b0;
                m_pend[i] <= 1'b0;
                m_prev[i] <= 1'b0;
            end
        end else begin
            m_irq <= m_gie && model_request();
            if (cpu_irq_ack) m_gie <= 1'b0;
            else if (de && drw && daddr[3:2] == 2'd0) m_gie <= din[0];
            for (int i = 0; i < NSRC; i++) begin
                m_prev[i] <= irq_src[i];
                if (de && drw && daddr[3:2] == 2'd1) m_mask[i] <= din[i];
                if (irq_src[i] && !m_prev[i]) m_pend[i] <= 1'b1;
                else if (de && drw && daddr[3:2] == 2'd2 && din[i]) m_pend[i] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: all outputs against the model every cycle
    always @(negedge clk) begin
        if (armed) begin
            check("cpu_irq", {31'd0, cpu_irq}, {31'd0, m_irq});
            check("iout", iout, 32'd0);
            check("dout", dout, model_read(de, drw, daddr[3:2]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        de = 1'b1; drw = 1'b1; daddr = {28'd0, sel, 2'b00}; din = d;
        next();
        de = 1'b0; drw = 1'b0; din = 32'd0;
    endtask

    task automatic rd_chk(input logic [1:0] sel, input logic [31:0] exp, input string name);
        de = 1'b1; drw = 1'b0; daddr = {28'd0, sel, 2'b00};
        #2;
        check(name, dout, exp);
        next();
        de = 1'b0;
    endtask

    task automatic irq_chk(input logic exp, input string name);
        check(name, {31'd0, cpu_irq}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; ie = 1'b0; de = 1'b0; drw = 1'b0; iaddr = 32'd0;
        daddr = 32'd0; din = 32'd0; irq_src = '0; cpu_irq_ack = 1'b0;
        next(); next();
        rst = 1'b0;

        // reset state
        irq_chk(1'b0, "reset_irq");
        check("reset_iout", iout, 32'd0);
        rd_chk(2'd0, 32'd0, "reset_ctrl");
        rd_chk(2'd1, 32'd0, "reset_mask");
        rd_chk(2'd2, 32'd0, "reset_status");
        rd_chk(2'd3, 32'd0, "reset_index");

        // single source, two-cycle latency
        wr(2'd1, 32'h04);
        wr(2'd0, 32'h01);
        irq_src[2] = 1'b1;
        next();
        irq_src[2] = 1'b0;
        irq_chk(1'b0, "lat_t1_irq");
        rd_chk(2'd2, 32'h04, "lat_t1_status");
        irq_chk(1'b1, "lat_t2_irq");
        rd_chk(2'd3, 32'h8000_0002, "lat_index");

        // two sources, lowest wins, W1C reveals next
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'hFF);
        irq_src = 8'h22;
        next();
        irq_src = 8'h00;
        rd_chk(2'd3, 32'h8000_0001, "prio_index1");
        wr(2'd2, 32'h02);
        rd_chk(2'd3, 32'h8000_0005, "prio_index5");
        irq_chk(1'b1, "prio_irq");

        // acknowledge handshake
        cpu_irq_ack = 1'b1;
        next();
        cpu_irq_ack = 1'b0;
        rd_chk(2'd0, 32'd0, "ack_gie");
        irq_chk(1'b0, "ack_irq");
        rd_chk(2'd2, 32'h20, "ack_status");
        wr(2'd0, 32'h01);
        next();
        irq_chk(1'b1, "reenable_irq");

        // held level gives one event; set beats same-cycle W1C
        wr(2'd2, 32'hFF);
        irq_src[4] = 1'b1;
        de = 1'b1; drw = 1'b1; daddr = 32'h8; din = 32'h10;
        next();
        de = 1'b0; drw = 1'b0; din = 32'd0;
        repeat (9) next();
        rd_chk(2'd2, 32'h10, "held_status");
        wr(2'd2, 32'h10);
        rd_chk(2'd2, 32'h00, "held_once");
        irq_src = 8'h00;

        // masked pending, then unmask
        wr(2'd1, 32'h00);
        irq_src[3] = 1'b1;
        next();
        irq_src = 8'h00;
        next(); next();
        irq_chk(1'b0, "masked_irq");
        rd_chk(2'd2, 32'h08, "masked_status");
        wr(2'd1, 32'h08);
        next();
        irq_chk(1'b1, "unmask_irq");

        // bits above NSRC discarded
        wr(2'd1, 32'hFFFF_FFFF);
        rd_chk(2'd1, 32'hFF, "mask_width");

        // mid-sequence reset
        rst = 1'b1;
        next();
        rst = 1'b0;
        irq_chk(1'b0, "rst_irq");
        rd_chk(2'd0, 32'd0, "rst_ctrl");
        rd_chk(2'd1, 32'd0, "rst_mask");
        rd_chk(2'd2, 32'd0, "rst_status");
        rd_chk(2'd3, 32'd0, "rst_index");

        // source held high through reset release
        irq_src[0] = 1'b1;
        rst = 1'b1;
        next(); next();
        rst = 1'b0;
        next();
        rd_chk(2'd2, 32'h01, "rst_held_src");
        irq_src = 8'h00;

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            de          = ($urandom_range(0, 3) != 0);
            drw         = $urandom_range(0, 1) == 1;
            daddr       = $urandom & 32'hFFFF_FFFC;
            din         = $urandom;
            ie          = $urandom_range(0, 1) == 1;
            iaddr       = $urandom;
            cpu_irq_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0)
                irq_src = irq_src ^ (8'd1 << $urandom_range(0, NSRC - 1));
            next();
        end
        rst = 1'b0; de = 1'b0; drw = 1'b0; cpu_irq_ack = 1'b0;
        next(); next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
